// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

  // Instruction-memory word-address width (1024-word memory).
  localparam int PC_WIDTH = 10;

  // Default instruction width.
  localparam int INST_WIDTH = 32;

  // Canonical no-op (addi x0, x0, 0) for downstream bubble insertion.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Word address loaded into the PC on reset unless overridden.
  localparam int unsigned RESET_PC_DEFAULT = 0;

  // Fetch FSM encodings.
  localparam logic [1:0] FETCH_S_BOOT = 2'd0;
  localparam logic [1:0] FETCH_S_RUN  = 2'd1;
  localparam logic [1:0] FETCH_S_HALT = 2'd2;

  typedef enum logic [1:0] {
    S_BOOT = FETCH_S_BOOT,
    S_RUN  = FETCH_S_RUN,
    S_HALT = FETCH_S_HALT
  } fetch_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// IF/ID valid/ready channel between fetch (master) and decode (slave).
interface fetch_unit_if #(
  parameter int PC_W   = fetch_unit_pkg::PC_WIDTH,
  parameter int INST_W = fetch_unit_pkg::INST_WIDTH
);
  logic              id_valid;
  logic              id_ready;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (output id_valid, output id_pc, output id_inst, input id_ready);
  modport slave  (input id_valid, input id_pc, input id_inst, output id_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory
// combinationally and registers {pc, inst} into the IF/ID stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_W     = PC_WIDTH,
  parameter int          INST_W   = INST_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_re,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  fetch_unit_if.master      id_bus,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              id_valid_q, id_valid_d;
  logic [PC_W-1:0]   id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic [31:0]       count_q, count_d;
  logic              halted_q, halted_d;
  logic              fire;

  // A fetch fires only when running, not stalled by halt or redirect,
  // and the IF/ID slot is empty or being consumed this cycle.
  assign fire = (state_q == S_RUN) && !halt_req && !redirect_valid &&
                (!id_valid_q || id_bus.id_ready);

  assign imem_re         = fire;
  assign imem_addr       = pc_q;
  assign id_bus.id_valid = id_valid_q;
  assign id_bus.id_pc    = id_pc_q;
  assign id_bus.id_inst  = id_inst_q;
  assign halted          = halted_q;
  assign fetch_count     = count_q;

  // FSM next state; a redirect freezes the state in every state.
  always_comb begin
    state_d = state_q;
    if (!redirect_valid) begin
      unique case (state_q)
        S_BOOT:  state_d = halt_req ? S_HALT : S_RUN;
        S_RUN:   if (halt_req) state_d = S_HALT;
        S_HALT:  if (!halt_req) state_d = S_RUN;
        default: state_d = S_BOOT;
      endcase
    end
    halted_d = (state_d == S_HALT);
  end

  // PC, IF/ID register and fetch counter next values: redirect flushes,
  // fire loads a new entry, otherwise a consumed entry drains.
  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
    end else if (fire) begin
      id_inst_d  = imem_rdata;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      pc_d       = pc_q + PC_W'(1);
      count_d    = sat_inc32(count_q);
    end else if (id_bus.id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= PC_W'(RESET_PC);
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      count_q    <= 32'd0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized run
// against a rule-level reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int PC_W   = 10;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_re;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              halt_req;
  logic              halted;
  logic [31:0]       fetch_count;
  logic              id_ready;
  logic [31:0]       mem_base;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W), .INST_W(INST_W)) id_bus ();
  assign id_bus.id_ready = id_ready;

  fetch_unit #(.RESET_PC(0), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_re        (imem_re),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .id_bus         (id_bus),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Instruction memory: word k holds mem_base + k, zero when not read.
  assign imem_rdata = imem_re ? (mem_base + 32'(imem_addr)) : 32'h0;

  // Reference model: 0 boot, 1 run, 2 halt.
  int              m_state = 0;
  logic [PC_W-1:0] m_pc    = '0;
  logic [PC_W-1:0] m_id_pc = '0;
  logic [31:0]     m_inst  = '0;
  logic [31:0]     m_count = '0;
  logic            m_valid  = 1'b0;
  logic            m_halted = 1'b0;

  function automatic logic m_fire();
    return (m_state == 1) && !halt_req && !redirect_valid && (!m_valid || id_ready);
  endfunction

  task automatic model_step();
    logic f;
    f = m_fire();
    if (!rst_n) begin
      m_state = 0; m_pc = '0; m_valid = 1'b0; m_id_pc = '0;
      m_inst = '0; m_count = '0; m_halted = 1'b0;
    end else if (redirect_valid) begin
      m_pc    = redirect_pc;
      m_valid = 1'b0;
    end else begin
      if (f) begin
        m_inst  = mem_base + 32'(m_pc);
        m_id_pc = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 1'b1;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end else if (id_ready) begin
        m_valid = 1'b0;
      end
      m_state  = halt_req ? 2 : 1;
      m_halted = (m_state == 2);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; id_ready = 1'b1;
    adv();
    adv();
    rst_n = 1'b1;
  endtask

  // Run with id_ready=1 until id_pc==target is valid (bounded).
  task automatic run_to(input logic [PC_W-1:0] target);
    bit found = 0;
    id_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (id_bus.id_valid && id_bus.id_pc == target) begin
        found = 1;
        break;
      end
      adv();
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL run_to timeout: id_pc never reached %h", target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h155;
    halt_req = 1'b0; id_ready = 1'b1;
    adv(); adv();
    #1;
    n_checks++;
    if ({id_bus.id_valid, halted, fetch_count, imem_addr, imem_re} !== {1'b0, 1'b0, 32'd0, 10'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b halted=%b count=%0d addr=%h re=%b, want 0 0 0 000 0",
               id_bus.id_valid, halted, fetch_count, imem_addr, imem_re);
    end
    $display("reset: state checked");
  endtask

  task automatic test_stream();
    mem_base = 32'h1000_0000;
    do_reset();
    #1;
    n_checks++;
    if (imem_re !== 1'b0) begin
      n_fail++; $display("FAIL boot_no_fetch: imem_re=%b want 0", imem_re);
    end
    adv(); #1;
    n_checks++;
    if ({imem_re, imem_addr} !== {1'b1, 10'd0}) begin
      n_fail++; $display("FAIL first_fetch: re=%b addr=%h want 1 000", imem_re, imem_addr);
    end
    adv();
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if ({id_bus.id_valid, id_bus.id_pc, id_bus.id_inst, fetch_count} !==
          {1'b1, 10'(k), 32'h1000_0000 + 32'(k), 32'(k + 1)}) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b pc=%h inst=%h count=%0d want 1 %h %h %0d", k,
                 id_bus.id_valid, id_bus.id_pc, id_bus.id_inst, fetch_count,
                 10'(k), 32'h1000_0000 + 32'(k), k + 1);
      end
      $display("stream: id_pc=%h id_inst=%h", id_bus.id_pc, id_bus.id_inst);
      adv();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    run_to(10'd5);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({id_bus.id_valid, id_bus.id_pc, id_bus.id_inst, imem_re, imem_addr} !==
          {1'b1, 10'd5, mem_base + 32'd5, 1'b0, 10'd6}) begin
        n_fail++;
        $display("FAIL stall_%0d: valid=%b pc=%h inst=%h re=%b addr=%h want 1 005 %h 0 006", i,
                 id_bus.id_valid, id_bus.id_pc, id_bus.id_inst, imem_re, imem_addr, mem_base + 32'd5);
      end
      adv();
    end
    id_ready = 1'b1;
    adv(); #1;
    n_checks++;
    if ({id_bus.id_valid, id_bus.id_pc} !== {1'b1, 10'd6}) begin
      n_fail++; $display("FAIL stall_release: valid=%b pc=%h want 1 006", id_bus.id_valid, id_bus.id_pc);
    end
    $display("backpressure: released id_pc=%h", id_bus.id_pc);
  endtask

  task automatic test_redirect();
    do_reset();
    run_to(10'd7);
    redirect_valid = 1'b1; redirect_pc = 10'h200;
    #1;
    n_checks++;
    if (imem_re !== 1'b0) begin
      n_fail++; $display("FAIL redirect_blocks_fetch: re=%b addr=%h want re 0", imem_re, imem_addr);
    end
    adv();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({id_bus.id_valid, imem_addr, imem_re} !== {1'b0, 10'h200, 1'b1}) begin
      n_fail++;
      $display("FAIL redirect_flush: valid=%b addr=%h re=%b want 0 200 1", id_bus.id_valid, imem_addr, imem_re);
    end
    adv(); #1;
    n_checks++;
    if ({id_bus.id_valid, id_bus.id_pc, id_bus.id_inst} !== {1'b1, 10'h200, mem_base + 32'h200}) begin
      n_fail++;
      $display("FAIL redirect_target: valid=%b pc=%h inst=%h want 1 200 %h",
               id_bus.id_valid, id_bus.id_pc, id_bus.id_inst, mem_base + 32'h200);
    end
    $display("redirect: id_pc=%h", id_bus.id_pc);
  endtask

  task automatic test_halt();
    do_reset();
    run_to(10'd19);
    halt_req = 1'b1;
    #1;
    n_checks++;
    if ({imem_re, halted} !== 2'b00) begin
      n_fail++; $display("FAIL halt_entry: re=%b halted=%b want 0 0", imem_re, halted);
    end
    adv();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({imem_re, id_bus.id_valid, halted, imem_addr} !== {1'b0, 1'b0, 1'b1, 10'd20}) begin
        n_fail++;
        $display("FAIL halted_%0d: re=%b valid=%b halted=%b addr=%h want 0 0 1 014", i,
                 imem_re, id_bus.id_valid, halted, imem_addr);
      end
      adv();
    end
    halt_req = 1'b0;
    #1;
    n_checks++;
    if ({imem_re, halted} !== 2'b01) begin
      n_fail++; $display("FAIL halt_release: re=%b halted=%b want 0 1", imem_re, halted);
    end
    adv(); #1;
    n_checks++;
    if ({imem_re, halted, imem_addr} !== {1'b1, 1'b0, 10'd20}) begin
      n_fail++; $display("FAIL halt_resume: re=%b halted=%b addr=%h want 1 0 014", imem_re, halted, imem_addr);
    end
    adv(); #1;
    n_checks++;
    if ({id_bus.id_valid, id_bus.id_pc} !== {1'b1, 10'd20}) begin
      n_fail++; $display("FAIL halt_first_pc: valid=%b pc=%h want 1 014", id_bus.id_valid, id_bus.id_pc);
    end
    $display("halt: resumed id_pc=%h", id_bus.id_pc);
  endtask

  task automatic test_wrap();
    do_reset();
    run_to(10'd2);
    redirect_valid = 1'b1; redirect_pc = 10'h3FF;
    adv();
    redirect_valid = 1'b0;
    adv(); #1;
    n_checks++;
    if ({id_bus.id_valid, id_bus.id_pc, imem_addr} !== {1'b1, 10'h3FF, 10'h000}) begin
      n_fail++;
      $display("FAIL wrap_last: valid=%b pc=%h addr=%h want 1 3ff 000", id_bus.id_valid, id_bus.id_pc, imem_addr);
    end
    adv(); #1;
    n_checks++;
    if ({id_bus.id_valid, id_bus.id_pc, id_bus.id_inst} !== {1'b1, 10'h000, mem_base}) begin
      n_fail++;
      $display("FAIL wrap_zero: valid=%b pc=%h inst=%h want 1 000 %h",
               id_bus.id_valid, id_bus.id_pc, id_bus.id_inst, mem_base);
    end
    $display("wrap: id_pc=%h", id_bus.id_pc);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    run_to(10'd4);
    id_ready = 1'b0;
    adv(); #1;
    n_checks++;
    if (id_bus.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: valid=%b want 1", id_bus.id_valid);
    end
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h123;
    adv(); #1;
    n_checks++;
    if ({id_bus.id_valid, imem_addr, fetch_count, halted} !== {1'b0, 10'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset: valid=%b addr=%h count=%0d halted=%b want 0 000 0 0",
               id_bus.id_valid, imem_addr, fetch_count, halted);
    end
    rst_n = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
    $display("midstream reset: addr=%h", imem_addr);
  endtask

  task automatic test_random();
    mem_base = $urandom;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = PC_W'($urandom);
      if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
      id_ready       = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if ({imem_re, imem_addr, id_bus.id_valid, halted, fetch_count, id_bus.id_pc, id_bus.id_inst} !==
          {m_fire(), m_pc, m_valid, m_halted, m_count, m_id_pc, m_inst}) begin
        n_fail++;
        $display("FAIL random_%0d: re=%b addr=%h v=%b h=%b cnt=%0d pc=%h inst=%h want %b %h %b %b %0d %h %h",
                 c, imem_re, imem_addr, id_bus.id_valid, halted, fetch_count, id_bus.id_pc, id_bus.id_inst,
                 m_fire(), m_pc, m_valid, m_halted, m_count, m_id_pc, m_inst);
      end
      adv();
    end
    $display("random: 600 cycles, fetch_count=%0d", fetch_count);
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; id_ready = 1'b1; mem_base = 32'h1000_0000;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's read-enable and word address.
- Samples the combinational read data in the same cycle.
- Presents {pc, inst} to decode through a registered valid/ready IF/ID output.
- Handles branch/jump redirect (flush), back-pressure from decode, and a halt request.

Parameters:
- RESET_PC, 0, word address loaded into the PC on reset.
- PC_W, `PC_WIDTH, PC / instruction-memory word-address width (10 for 1024-word memory).
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_re  out  1  instruction memory read enable; high only in cycles where a fetch fires.
- imem_addr  out  PC_W  instruction memory word address; always equals current pc.
- imem_rdata  in  INST_W  combinational read data for imem_addr; 0 when imem_re low.
- redirect_valid  in  1  taken branch/jump/exception redirect this cycle.
- redirect_pc  in  PC_W  word address to fetch next when redirect_valid.
- halt_req  in  1  level; stop fetching while high.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_ready  in  1  decode accepts IF/ID contents this cycle.
- id_pc  out  PC_W  word address of id_inst.
- id_inst  out  INST_W  fetched instruction.
- halted  out  1  high while in S_HALT.
- fetch_count  out  32  number of fetches fired since reset; saturating.

Behaviour:
- Reset (rst_n low at an edge): pc=RESET_PC, state=S_BOOT, id_valid=0, id_pc=0, id_inst=0, fetch_count=0, halted=0. Reset overrides every other input.
- FSM states: S_BOOT, S_RUN, S_HALT.
  - S_BOOT: one cycle, never fetches. Goes to S_HALT if halt_req, else S_RUN.
  - S_RUN: goes to S_HALT when halt_req=1.
  - S_HALT: goes to S_RUN when halt_req=0.
- fire = (state==S_RUN) && !halt_req && !redirect_valid && (!id_valid || id_ready).
  - imem_re = fire (combinational).
  - imem_addr = pc, always driven.
- On fire at an edge:
  - id_inst <= imem_rdata
  - id_pc <= pc
  - id_valid <= 1
  - pc <= pc+1, wrapping from 2^PC_W-1 to 0
  - fetch_count += 1, saturating at 32'hFFFF_FFFF
- Latency: address presented in cycle N, instruction visible on id_* in cycle N+1. Sustained throughput is 1 instruction/cycle while id_ready=1.
- Back-pressure: id_valid=1 with id_ready=0 holds id_pc, id_inst, id_valid and pc unchanged, and no fetch fires.
- Drain: id_valid=1, id_ready=1 and no fire (halt, redirect, or boot) clears id_valid to 0.
- Redirect has highest priority after reset, in any state:
  - pc <= redirect_pc, id_valid <= 0 (flush), no fetch that cycle.
  - State is unchanged. A redirect in S_HALT or S_BOOT only updates pc.
  - If id_ready=1 at the same edge, decode's handshake still completes; the flush discards nothing extra.
- Halt:
  - A halt_req=1 cycle in S_RUN blocks the fetch combinationally in that same cycle.
  - The IF/ID entry drains normally under id_ready.
  - halted is registered: high from the cycle after entering S_HALT.
  - pc is preserved across halt, so fetching resumes at the next unfetched address.
- Wrap: fetch at pc=2^PC_W-1 yields next pc=0. No error flag.
- id_inst and id_pc keep their last values when id_valid=0; they are not zeroed.

Decomposition:
- defines_bitwidth.vh already supplies PC_WIDTH.
- Add to the shared header: INST_NOP (32'h0000_0013), the FSM state encodings FETCH_S_BOOT/RUN/HALT (2-bit), and RESET_PC default.
- No sub-module: pc register, FSM, IF/ID register and counter live in one module. The PC incrementer stays inline.

Test Plan:
1. Reset then run, id_ready=1, memory word k = 32'h1000_0000+k.
   - First imem_re in cycle 2 after reset release.
   - id_valid rises the next cycle with id_pc=0, id_inst=32'h1000_0000, then id_pc 1,2,3… every cycle.
   - fetch_count tracks fetches.
2. Back-pressure: hold id_ready=0 for 3 cycles while id_pc=5.
   - id_pc=5 and id_inst stable, imem_re=0, pc=6.
   - On release, the next cycle shows id_pc=6.
3. Redirect with redirect_pc=10'h200 while id_pc=7 is valid.
   - Next cycle id_valid=0.
   - Following cycle id_pc=10'h200; address 8 is never presented with imem_re=1.
4. Halt: halt_req=1 for 4 cycles at pc=20, id_ready=1.
   - No imem_re, id_valid drops after drain, halted=1 from the cycle after entry.
   - After release the first fetched id_pc=20.
5. Wrap: redirect to 10'h3FF with id_ready=1.
   - Consecutive id_pc values 10'h3FF then 10'h000.
6. Reset mid-stream (rst_n=0 during a stall with id_valid=1).
   - At the edge id_valid=0, pc=RESET_PC, fetch_count=0.
   - Simultaneous redirect_valid is ignored.
